psum_pingpong_buffer: RTL and testbench

// - Parametrised successor to the single-bank partial-sum buffer in the PE system top.
// - Two banks (ping-pong) of ARRAY_DIM lanes x ACC_WIDTH words. The PE array accumulates

---
 rtl/psum_pingpong_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_psum_pingpong_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_pingpong_buffer.sv
// Two-bank partial-sum buffer: accumulate into one bank while the other drains as a valid/ready stream.
// Accumulate RMW is 2 cycles; first result beat is 3 cycles after bank_done; stalled beats hold on !out_ready.
module psum_pingpong_buffer #(
  parameter int ARRAY_DIM  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_acc_valid,
  input  logic                           i_acc_first,
  input  logic [ADDR_WIDTH-1:0]          i_acc_addr,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] i_psum_in,
  output logic                           o_acc_ready,
  input  logic                           i_bank_done,
  input  logic [ADDR_WIDTH:0]            i_drain_len,
  input  logic                           i_relu_en,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0] o_out_data,
  output logic [ADDR_WIDTH-1:0]          o_out_addr,
  output logic                           o_out_last,
  output logic                           o_sat_flag,
  output logic                           o_drop_err
);

  localparam int DW = ARRAY_DIM * ACC_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ACC_WIDTH-1:0] LP_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] LP_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_st_t;

  bank_st_t            r_state [2];
  bank_st_t            w_state_nxt [2];
  logic [ADDR_WIDTH:0] r_len [2];
  logic                r_relu [2];
  logic                r_settled [2];

  logic [DW-1:0] r_mem [0:2*DEPTH-1];

  logic                  r_p_vld;
  logic                  r_p_first;
  logic                  r_p_bank;
  logic [ADDR_WIDTH-1:0] r_p_addr;
  logic [DW-1:0]         r_p_psum;
  logic [DW-1:0]         r_p_old;
  logic [DW-1:0]         w_wr_data;
  logic                  w_wr_sat;
  logic [ACC_WIDTH-1:0]  w_la, w_lb, w_ls;

  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DW-1:0]         w_rd_word;
  logic [DW-1:0]         w_rd_out;

  logic                w_fill_any, w_fill_bank;
  logic                w_drain_any, w_drain_bank;
  logic                w_acc_fire, w_done_fire, w_last_acc;
  logic                w_fwd, w_rd_avail, w_out_load;
  logic [ADDR_WIDTH:0] w_len_clip;
  logic [1:0]          w_take, w_start;

  assign w_fill_any   = (r_state[0] == ST_FILLING) || (r_state[1] == ST_FILLING);
  assign w_fill_bank  = (r_state[1] == ST_FILLING);
  assign w_drain_any  = (r_state[0] == ST_DRAINING) || (r_state[1] == ST_DRAINING);
  assign w_drain_bank = (r_state[1] == ST_DRAINING);
  assign o_acc_ready  = w_fill_any;

  assign w_acc_fire  = i_acc_valid && w_fill_any;
  assign w_done_fire = i_bank_done && w_fill_any;
  assign w_last_acc  = o_out_valid && i_out_ready && o_out_last;
  assign w_len_clip  = (i_drain_len > LP_DEPTH) ? LP_DEPTH : i_drain_len;
  assign w_fwd       = r_p_vld && (r_p_bank == w_fill_bank) && (r_p_addr == i_acc_addr);

  // A freed bank is claimed for filling only when nothing else is filling; bank0 wins ties.
  assign w_take[0]  = (r_state[0] == ST_FREE) &&
                      (!w_fill_any || (w_done_fire && w_fill_bank));
  assign w_take[1]  = (r_state[1] == ST_FREE) &&
                      ((!w_fill_any && (r_state[0] != ST_FREE)) || (w_done_fire && !w_fill_bank));
  // r_settled delays drain by one cycle so the closing beat's write lands first.
  assign w_start[0] = (r_state[0] == ST_FULL) && r_settled[0] && !w_drain_any;
  assign w_start[1] = (r_state[1] == ST_FULL) && r_settled[1] && !w_drain_any && !w_start[0];

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      case (r_state[b])
        ST_FREE:     if (w_take[b])    w_state_nxt[b] = ST_FILLING;
        ST_FILLING:  if (w_done_fire)  w_state_nxt[b] = (w_len_clip == '0) ? ST_FREE : ST_FULL;
        ST_FULL:     if (w_start[b])   w_state_nxt[b] = ST_DRAINING;
        ST_DRAINING: if (w_last_acc)   w_state_nxt[b] = ST_FREE;
      endcase
    end
  end

  always_comb begin
    w_wr_data = r_p_psum;
    w_wr_sat  = 1'b0;
    w_la      = '0;
    w_lb      = '0;
    w_ls      = '0;
    if (!r_p_first) begin
      for (int i = 0; i < ARRAY_DIM; i++) begin
        w_la = r_p_old[i*ACC_WIDTH +: ACC_WIDTH];
        w_lb = r_p_psum[i*ACC_WIDTH +: ACC_WIDTH];
        w_ls = w_la + w_lb;
        if ((w_la[ACC_WIDTH-1] == w_lb[ACC_WIDTH-1]) && (w_ls[ACC_WIDTH-1] != w_la[ACC_WIDTH-1])) begin
          w_wr_data[i*ACC_WIDTH +: ACC_WIDTH] = w_la[ACC_WIDTH-1] ? LP_MIN : LP_MAX;
          w_wr_sat = 1'b1;
        end else begin
          w_wr_data[i*ACC_WIDTH +: ACC_WIDTH] = w_ls;
        end
      end
    end
  end

  assign w_rd_word  = r_mem[{w_drain_bank, r_rd_ptr[ADDR_WIDTH-1:0]}];
  assign w_rd_avail = w_drain_any && (r_rd_ptr < r_len[w_drain_bank]);
  assign w_out_load = w_rd_avail && (!o_out_valid || i_out_ready);

  always_comb begin
    w_rd_out = w_rd_word;
    if (r_relu[w_drain_bank]) begin
      for (int i = 0; i < ARRAY_DIM; i++) begin
        if (w_rd_word[i*ACC_WIDTH + ACC_WIDTH - 1]) w_rd_out[i*ACC_WIDTH +: ACC_WIDTH] = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_p_vld && !i_rst) r_mem[{r_p_bank, r_p_addr}] <= w_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state[0]  <= ST_FILLING;
      r_state[1]  <= ST_FREE;
      for (int b = 0; b < 2; b++) begin
        r_len[b]     <= '0;
        r_relu[b]    <= 1'b0;
        r_settled[b] <= 1'b0;
      end
      r_p_vld     <= 1'b0;
      r_p_first   <= 1'b0;
      r_p_bank    <= 1'b0;
      r_p_addr    <= '0;
      r_p_psum    <= '0;
      r_p_old     <= '0;
      r_rd_ptr    <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_addr  <= '0;
      o_out_last  <= 1'b0;
      o_sat_flag  <= 1'b0;
      o_drop_err  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_state[b]   <= w_state_nxt[b];
        r_settled[b] <= (r_state[b] == ST_FULL);
        if (w_done_fire && (w_fill_bank == 1'(b))) begin
          r_len[b]  <= w_len_clip;
          r_relu[b] <= i_relu_en;
        end
      end

      r_p_vld <= w_acc_fire;
      if (w_acc_fire) begin
        r_p_first <= i_acc_first;
        r_p_bank  <= w_fill_bank;
        r_p_addr  <= i_acc_addr;
        r_p_psum  <= i_psum_in;
        r_p_old   <= w_fwd ? w_wr_data : r_mem[{w_fill_bank, i_acc_addr}];
      end

      if (w_start != 2'b00) begin
        r_rd_ptr <= '0;
      end else if (w_out_load) begin
        r_rd_ptr <= r_rd_ptr + LP_ONE;
      end

      if (w_out_load) begin
        o_out_valid <= 1'b1;
        o_out_data  <= w_rd_out;
        o_out_addr  <= r_rd_ptr[ADDR_WIDTH-1:0];
        o_out_last  <= ((r_rd_ptr + LP_ONE) == r_len[w_drain_bank]);
      end else if (i_out_ready) begin
        o_out_valid <= 1'b0;
        o_out_last  <= 1'b0;
      end

      o_sat_flag <= o_sat_flag | (r_p_vld && w_wr_sat);
      o_drop_err <= o_drop_err | ((i_acc_valid || i_bank_done) && !w_fill_any);
    end
  end

endmodule

// File: tb/tb_psum_pingpong_buffer.sv
// Scoreboard bench for psum_pingpong_buffer: a bank-agnostic fill model queues expected beats at bank_done.
module tb_psum_pingpong_buffer;

  localparam int AD    = 16;
  localparam int LW    = 32;
  localparam int DEPTH = 1024;
  localparam int AWD   = 10;
  localparam int W     = AD * LW;
  localparam int CW    = 512;

  logic           clk, rst;
  logic           acc_valid, acc_first;
  logic [AWD-1:0] acc_addr;
  logic [W-1:0]   psum;
  logic           acc_ready;
  logic           bank_done;
  logic [AWD:0]   drain_len;
  logic           relu_en;
  logic           out_valid, out_ready, out_last;
  logic [W-1:0]   out_data;
  logic [AWD-1:0] out_addr;
  logic           sat_flag, drop_err;

  psum_pingpong_buffer #(.ARRAY_DIM(AD), .ACC_WIDTH(LW), .DEPTH(DEPTH), .ADDR_WIDTH(AWD)) dut (
    .i_clk(clk), .i_rst(rst), .i_acc_valid(acc_valid), .i_acc_first(acc_first),
    .i_acc_addr(acc_addr), .i_psum_in(psum), .o_acc_ready(acc_ready),
    .i_bank_done(bank_done), .i_drain_len(drain_len), .i_relu_en(relu_en),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_addr(out_addr), .o_out_last(out_last), .o_sat_flag(sat_flag), .o_drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   dat;
    logic [AWD-1:0] addr;
    logic           last;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] fb [int];
  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lanes(input logic [31:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < AD; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int i = 0; i < AD; i++) r[i*LW +: LW] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] m_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    longint s;
    for (int i = 0; i < AD; i++) begin
      s = longint'($signed(a[i*LW +: LW])) + longint'($signed(b[i*LW +: LW]));
      if (s > 64'sd2147483647)       r[i*LW +: LW] = 32'h7FFF_FFFF;
      else if (s < -64'sd2147483648) r[i*LW +: LW] = 32'h8000_0000;
      else                           r[i*LW +: LW] = s[31:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] m_relu(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = a;
    for (int i = 0; i < AD; i++) if ($signed(a[i*LW +: LW]) < 0) r[i*LW +: LW] = '0;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bank(input int len, input logic relu);
    exp_t e;
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    for (int a = 0; a < n; a++) begin
      e.dat  = relu ? m_relu(fb[a]) : fb[a];
      e.addr = AWD'(a);
      e.last = (a == n - 1);
      sbq.push_back(e);
    end
    fb.delete();
  endtask

  task automatic beat(input logic first, input int addr, input logic [W-1:0] p,
                      input logic done, input int len, input logic relu);
    acc_valid = 1'b1;
    acc_first = first;
    acc_addr  = AWD'(addr);
    psum      = p;
    bank_done = done;
    drain_len = (AWD+1)'(len);
    relu_en   = relu;
    fb[addr]  = first ? p : m_add(fb[addr], p);
    if (done) push_bank(len, relu);
    step();
    acc_valid = 1'b0;
    bank_done = 1'b0;
  endtask

  task automatic close(input int len, input logic relu);
    bank_done = 1'b1;
    drain_len = (AWD+1)'(len);
    relu_en   = relu;
    push_bank(len, relu);
    step();
    bank_done = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && (sbq.size() != 0 || out_valid); i++) step();
    chk(tag, CW'(sbq.size()), CW'(0));
  endtask

  // Output monitor: scoreboard compare on accept, hold-stable check after a stall.
  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_dat;
  logic [AWD-1:0] prev_addr;
  logic           prev_last;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld",  CW'(out_valid), CW'(1));
        chk("hold_dat",  CW'(out_data),  CW'(prev_dat));
        chk("hold_addr", CW'(out_addr),  CW'(prev_addr));
        chk("hold_last", CW'(out_last),  CW'(prev_last));
      end
      if (out_valid && out_ready) begin
        chk("sb_has_exp", CW'(sbq.size() != 0), CW'(1));
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("beat_dat",  CW'(out_data), CW'(e.dat));
          chk("beat_addr", CW'(out_addr), CW'(e.addr));
          chk("beat_last", CW'(out_last), CW'(e.last));
          n_beats++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_addr  = out_addr;
      prev_last  = out_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cnt;
    logic saw;
    logic [W-1:0] wa, wb;

    rst = 1'b1; acc_valid = 1'b0; acc_first = 1'b0; acc_addr = '0; psum = '0;
    bank_done = 1'b0; drain_len = '0; relu_en = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_acc_ready", CW'(acc_ready), CW'(1));
    chk("rst_out_valid", CW'(out_valid), CW'(0));
    chk("rst_out_last",  CW'(out_last),  CW'(0));
    chk("rst_out_addr",  CW'(out_addr),  CW'(0));
    chk("rst_out_data",  CW'(out_data),  CW'(0));
    chk("rst_sat",       CW'(sat_flag),  CW'(0));
    chk("rst_drop",      CW'(drop_err),  CW'(0));

    // 1) overwrite then three back-to-back adds to the same word, exact drain latency
    beat(1'b1, 0, lanes(32'd5), 1'b0, 0, 1'b0);
    for (int k = 0; k < 3; k++) beat(1'b0, 0, lanes(32'd2), 1'b0, 0, 1'b0);
    close(1, 1'b0);
    chk("t1_lat0", CW'(out_valid), CW'(0));
    step(); chk("t1_lat1", CW'(out_valid), CW'(0));
    step(); chk("t1_lat2", CW'(out_valid), CW'(0));
    step(); chk("t1_lat3", CW'(out_valid), CW'(1));
    chk("t1_data", CW'(out_data), CW'(lanes(32'd11)));
    chk("t1_last", CW'(out_last), CW'(1));
    wait_drain("t1_drain");
    chk("t1_sat_clear", CW'(sat_flag), CW'(0));

    // 2) saturation both ways, ReLU, and a beat sharing the bank_done cycle
    for (int i = 0; i < AD; i++) begin
      wa[i*LW +: LW] = (i % 2 == 0) ? 32'h7FFF_FFF0 : 32'h8000_0010;
      wb[i*LW +: LW] = (i % 2 == 0) ? 32'h0000_0020 : 32'hFFFF_FFE0;
    end
    beat(1'b1, 0, wa, 1'b0, 0, 1'b0);
    beat(1'b0, 0, wb, 1'b0, 0, 1'b0);
    beat(1'b1, 1, lanes(32'hFFFF_FFFB), 1'b1, 2, 1'b1);
    wait_drain("t2_drain");
    chk("t2_sat", CW'(sat_flag), CW'(1));

    // 3) both banks occupied -> fill stalls, dropped beat flagged, released by drain
    out_ready = 1'b0;
    for (int a = 0; a < 8; a++) beat(1'b1, a, rnd_word(), 1'b0, 0, 1'b0);
    close(8, 1'b0);
    chk("t3_rdy_swap", CW'(acc_ready), CW'(1));
    for (int a = 0; a < 4; a++) beat(1'b1, a, rnd_word(), 1'b0, 0, 1'b0);
    close(4, 1'b0);
    chk("t3_rdy_low", CW'(acc_ready), CW'(0));
    chk("t3_drop_pre", CW'(drop_err), CW'(0));
    acc_valid = 1'b1; acc_first = 1'b0; acc_addr = AWD'(2); psum = lanes(32'd100);
    step();
    acc_valid = 1'b0;
    chk("t3_drop", CW'(drop_err), CW'(1));
    chk("t3_rdy_hold", CW'(acc_ready), CW'(0));
    base = n_beats;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !acc_ready; i++) step();
    chk("t3_rdy_rise", CW'(acc_ready), CW'(1));
    chk("t3_beats_b0", CW'(n_beats - base), CW'(8));
    wait_drain("t3_drain");

    // 4) 16-beat drain under alternating backpressure
    for (int a = 0; a < 16; a++) beat(1'b1, a, rnd_word(), 1'b0, 0, 1'b0);
    base = n_beats;
    out_ready = 1'b0;
    close(16, 1'b0);
    for (int i = 0; i < 200 && (sbq.size() != 0 || out_valid); i++) begin
      out_ready = ~out_ready;
      step();
    end
    out_ready = 1'b1;
    chk("t4_drain", CW'(sbq.size()), CW'(0));
    chk("t4_beats", CW'(n_beats - base), CW'(16));

    // 6) fill one bank while the other drains continuously
    for (int a = 0; a < 32; a++) beat(1'b1, a, rnd_word(), 1'b0, 0, 1'b0);
    close(32, 1'b0);
    saw = 1'b0;
    for (int a = 0; a < 32; a++) begin
      saw |= out_valid;
      beat(1'b1, a, rnd_word(), 1'b0, 0, 1'b0);
    end
    for (int a = 0; a < 16; a++) beat(1'b0, a / 2, rnd_word(), 1'b0, 0, 1'b0);
    chk("t6_overlap", CW'(saw), CW'(1));
    chk("t6_rdy", CW'(acc_ready), CW'(1));
    close(32, 1'b1);
    wait_drain("t6_drain");

    // 5) empty close, then reset in the middle of a stalled drain
    close(0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) cnt++;
    end
    chk("t5_len0_quiet", CW'(cnt), CW'(0));
    chk("t5_len0_rdy", CW'(acc_ready), CW'(1));
    beat(1'b1, 0, rnd_word(), 1'b0, 0, 1'b0);
    beat(1'b1, 1, rnd_word(), 1'b0, 0, 1'b0);
    close(2, 1'b0);
    wait_drain("t5_reuse");
    for (int a = 0; a < 8; a++) beat(1'b1, a, rnd_word(), 1'b0, 0, 1'b0);
    out_ready = 1'b0;
    close(8, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("t5_vld_up", CW'(out_valid), CW'(1));
    rst = 1'b1;
    step();
    sbq.delete();
    fb.delete();
    chk("t5_rst_vld",  CW'(out_valid), CW'(0));
    chk("t5_rst_rdy",  CW'(acc_ready), CW'(1));
    chk("t5_rst_last", CW'(out_last),  CW'(0));
    chk("t5_rst_sat",  CW'(sat_flag),  CW'(0));
    chk("t5_rst_drop", CW'(drop_err),  CW'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    for (int a = 0; a < 3; a++) beat(1'b1, a, rnd_word(), 1'b0, 0, 1'b0);
    close(3, 1'b1);
    wait_drain("t5_post_rst");

    chk("end_sb_empty", CW'(sbq.size()), CW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
